// File: rtl/repne_cmps_sequencer_wb_if.sv
// Handshake and data bundle between writeback control and the
// REPNE CMPS sequencer.
interface repne_cmps_sequencer_wb_if #(
    parameter int COUNT_W = 32
);
    logic               start;
    logic [COUNT_W-1:0] init_count;
    logic [COUNT_W-1:0] init_esi;
    logic [COUNT_W-1:0] init_edi;
    logic [1:0]         size;
    logic               df;
    logic               cmp_done;
    logic               zf;
    logic               stall_in;
    logic               busy;
    logic               first_uop;
    logic               second_uop;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] esi;
    logic [COUNT_W-1:0] edi;
    logic               ld_gpr;
    logic               terminate;
    logic               ld_eip;

    modport master (
        output start, init_count, init_esi, init_edi,
        output size, df, cmp_done, zf, stall_in,
        input  busy, first_uop, second_uop,
        input  count, esi, edi,
        input  ld_gpr, terminate, ld_eip
    );

    modport slave (
        input  start, init_count, init_esi, init_edi,
        input  size, df, cmp_done, zf, stall_in,
        output busy, first_uop, second_uop,
        output count, esi, edi,
        output ld_gpr, terminate, ld_eip
    );
endinterface

// File: rtl/repne_cmps_sequencer_wb.sv
// REPNE CMPS repeat sequencer at writeback: issues the two CMPS
// micro-ops per iteration, walks ECX/ESI/EDI and ends on ZF or ECX==0.
module repne_cmps_sequencer_wb #(
    parameter int COUNT_W = 32
) (
    input logic                       CLK,
    input logic                       CLR,
    repne_cmps_sequencer_wb_if.slave  bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_UOP1 = 3'd1;
    localparam logic [2:0] S_UOP2 = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] esi_q, esi_d;
    logic [COUNT_W-1:0] edi_q, edi_d;
    logic               ld_gpr_q, ld_gpr_d;
    logic [COUNT_W-1:0] step;
    logic [COUNT_W-1:0] count_dec;

    always_comb begin
        unique case (bus.size)
            2'd0:    step = COUNT_W'(1);
            2'd1:    step = COUNT_W'(2);
            default: step = COUNT_W'(4);
        endcase
    end

    assign count_dec = count_q - COUNT_W'(1);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        esi_d    = esi_q;
        edi_d    = edi_q;
        ld_gpr_d = ld_gpr_q;
        // A stall freezes everything, including a pending ld_gpr.
        if (!bus.stall_in) begin
            ld_gpr_d = 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        count_d = bus.init_count;
                        esi_d   = bus.init_esi;
                        edi_d   = bus.init_edi;
                        state_d = (bus.init_count == '0) ? S_DONE : S_UOP1;
                    end
                end
                S_UOP1: state_d = S_UOP2;
                S_UOP2: state_d = S_WAIT;
                S_WAIT: begin
                    if (bus.cmp_done) begin
                        count_d  = count_dec;
                        esi_d    = bus.df ? esi_q - step : esi_q + step;
                        edi_d    = bus.df ? edi_q - step : edi_q + step;
                        ld_gpr_d = 1'b1;
                        state_d  = (bus.zf || count_dec == '0) ? S_DONE
                                                               : S_UOP1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            esi_q    <= '0;
            edi_q    <= '0;
            ld_gpr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            esi_q    <= esi_d;
            edi_q    <= edi_d;
            ld_gpr_q <= ld_gpr_d;
        end
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.first_uop  = (state_q == S_UOP1);
    assign bus.second_uop = (state_q == S_UOP2);
    assign bus.terminate  = (state_q == S_DONE);
    assign bus.ld_eip     = (state_q == S_DONE);
    assign bus.ld_gpr     = ld_gpr_q;
    assign bus.count      = count_q;
    assign bus.esi        = esi_q;
    assign bus.edi        = edi_q;
endmodule

// File: tb/tb_repne_cmps_sequencer_wb.sv
// Scenario bench for the REPNE CMPS sequencer with a per-iteration
// register scoreboard.
module tb_repne_cmps_sequencer_wb;
    logic CLK;
    logic CLR;

    repne_cmps_sequencer_wb_if #(.COUNT_W(32)) bus ();

    repne_cmps_sequencer_wb #(.COUNT_W(32)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] c;
        logic [31:0] e;
        logic [31:0] d;
        logic        last;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;
    int uop1_cnt = 0;
    int uop2_cnt = 0;
    int term_cnt = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(negedge CLK) begin
        if (bus.first_uop)  uop1_cnt++;
        if (bus.second_uop) uop2_cnt++;
        if (bus.terminate)  term_cnt++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        CLR = 1'b1;
        tick();
        tick();
        CLR = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.terminate !== 1'b0 ||
            bus.ld_eip !== 1'b0 || bus.ld_gpr !== 1'b0 ||
            bus.first_uop !== 1'b0 || bus.second_uop !== 1'b0) begin
            failures++;
            $display("FAIL reset_bits: got busy=%b term=%b eip=%b gpr=%b u1=%b u2=%b want all 0",
                     bus.busy, bus.terminate, bus.ld_eip, bus.ld_gpr,
                     bus.first_uop, bus.second_uop);
        end
        checks++;
        if (bus.count !== 32'h0 || bus.esi !== 32'h0 || bus.edi !== 32'h0) begin
            failures++;
            $display("FAIL reset_regs: got %h %h %h want 0 0 0",
                     bus.count, bus.esi, bus.edi);
        end
    endtask

    task automatic test_zero_count();
        int u1, u2, t0;
        u1 = uop1_cnt; u2 = uop2_cnt; t0 = term_cnt;
        bus.start = 1'b1;
        bus.init_count = 32'h0;
        bus.init_esi = 32'h55;
        bus.init_edi = 32'h66;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.terminate !== 1'b1 || bus.ld_eip !== 1'b1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL zero_term_t1: got term=%b eip=%b busy=%b want 1 1 1",
                     bus.terminate, bus.ld_eip, bus.busy);
        end
        checks++;
        if (bus.esi !== 32'h55 || bus.edi !== 32'h66) begin
            failures++;
            $display("FAIL zero_latch: got %h %h want 55 66", bus.esi, bus.edi);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.terminate !== 1'b0) begin
            failures++;
            $display("FAIL zero_idle_t2: got busy=%b term=%b want 0 0",
                     bus.busy, bus.terminate);
        end
        checks++;
        if (uop1_cnt != u1 || uop2_cnt != u2 || term_cnt != t0 + 1) begin
            failures++;
            $display("FAIL zero_counts: got u1=%0d u2=%0d term=%0d want 0 0 1",
                     uop1_cnt - u1, uop2_cnt - u2, term_cnt - t0);
        end
    endtask

    task automatic test_rep(input string name, input logic [31:0] cnt,
                            input logic [31:0] e0, input logic [31:0] d0,
                            input logic [1:0] sz, input logic dfv,
                            input int zf_at);
        logic [31:0] c, e, d, st;
        int n, u1, u2, t0;
        exp_t x;
        st = (sz == 2'd0) ? 32'd1 : (sz == 2'd1) ? 32'd2 : 32'd4;
        c = cnt; e = e0; d = d0; n = 0;
        do begin
            c = c - 32'd1;
            e = dfv ? e - st : e + st;
            d = dfv ? d - st : d + st;
            n++;
            x.c = c; x.e = e; x.d = d;
            x.last = (n == zf_at) || (c == 32'h0);
            q.push_back(x);
        end while (!x.last);
        u1 = uop1_cnt; u2 = uop2_cnt; t0 = term_cnt;
        bus.start = 1'b1;
        bus.init_count = cnt;
        bus.init_esi = e0;
        bus.init_edi = d0;
        bus.size = sz;
        bus.df = dfv;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (bus.first_uop !== 1'b1) begin
                failures++;
                $display("FAIL %s uop1[%0d]: got %b want 1", name, i, bus.first_uop);
            end
            tick();
            checks++;
            if (bus.second_uop !== 1'b1) begin
                failures++;
                $display("FAIL %s uop2[%0d]: got %b want 1", name, i, bus.second_uop);
            end
            tick();
            bus.cmp_done = 1'b1;
            bus.zf = (i + 1 == zf_at);
            tick();
            bus.cmp_done = 1'b0;
            bus.zf = 1'b0;
            x = q.pop_front();
            checks++;
            if (bus.ld_gpr !== 1'b1 || bus.count !== x.c ||
                bus.esi !== x.e || bus.edi !== x.d) begin
                failures++;
                $display("FAIL %s iter[%0d]: got gpr=%b %h %h %h want 1 %h %h %h",
                         name, i, bus.ld_gpr, bus.count, bus.esi, bus.edi,
                         x.c, x.e, x.d);
            end
            checks++;
            if (bus.terminate !== x.last) begin
                failures++;
                $display("FAIL %s term[%0d]: got %b want %b",
                         name, i, bus.terminate, x.last);
            end
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.ld_gpr !== 1'b0) begin
            failures++;
            $display("FAIL %s end_idle: got busy=%b gpr=%b want 0 0",
                     name, bus.busy, bus.ld_gpr);
        end
        checks++;
        if (uop1_cnt - u1 != n || uop2_cnt - u2 != n ||
            term_cnt - t0 != 1 || q.size() != 0) begin
            failures++;
            $display("FAIL %s counts: got u1=%0d u2=%0d term=%0d q=%0d want %0d %0d 1 0",
                     name, uop1_cnt - u1, uop2_cnt - u2, term_cnt - t0,
                     q.size(), n, n);
        end
    endtask

    task automatic test_stall();
        int u2;
        bus.start = 1'b1;
        bus.init_count = 32'd2;
        bus.init_esi = 32'h10;
        bus.init_edi = 32'h20;
        bus.size = 2'd0;
        bus.df = 1'b0;
        tick();
        bus.start = 1'b0;
        u2 = uop2_cnt;
        tick();
        bus.stall_in = 1'b1;
        bus.cmp_done = 1'b1;
        tick();
        bus.cmp_done = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.second_uop !== 1'b1 || bus.count !== 32'd2 || bus.ld_gpr !== 1'b0) begin
            failures++;
            $display("FAIL stall_uop2_hold: got u2=%b cnt=%h gpr=%b want 1 2 0",
                     bus.second_uop, bus.count, bus.ld_gpr);
        end
        bus.stall_in = 1'b0;
        tick();
        checks++;
        if (bus.second_uop !== 1'b0 || uop2_cnt - u2 != 4) begin
            failures++;
            $display("FAIL stall_uop2_len: got u2=%b cycles=%0d want 0 4",
                     bus.second_uop, uop2_cnt - u2);
        end
        bus.stall_in = 1'b1;
        bus.cmp_done = 1'b1;
        tick();
        checks++;
        if (bus.ld_gpr !== 1'b0 || bus.count !== 32'd2) begin
            failures++;
            $display("FAIL stall_cmp_ignored: got gpr=%b cnt=%h want 0 2",
                     bus.ld_gpr, bus.count);
        end
        bus.stall_in = 1'b0;
        tick();
        bus.cmp_done = 1'b0;
        checks++;
        if (bus.ld_gpr !== 1'b1 || bus.count !== 32'd1 || bus.esi !== 32'h11 ||
            bus.edi !== 32'h21 || bus.first_uop !== 1'b1) begin
            failures++;
            $display("FAIL stall_consume: got gpr=%b %h %h %h u1=%b want 1 1 11 21 1",
                     bus.ld_gpr, bus.count, bus.esi, bus.edi, bus.first_uop);
        end
        tick();
        checks++;
        if (bus.count !== 32'd1 || bus.ld_gpr !== 1'b0) begin
            failures++;
            $display("FAIL stall_once: got cnt=%h gpr=%b want 1 0",
                     bus.count, bus.ld_gpr);
        end
        tick();
        bus.cmp_done = 1'b1;
        bus.zf = 1'b1;
        tick();
        bus.cmp_done = 1'b0;
        bus.zf = 1'b0;
        checks++;
        if (bus.terminate !== 1'b1 || bus.count !== 32'd0) begin
            failures++;
            $display("FAIL stall_finish: got term=%b cnt=%h want 1 0",
                     bus.terminate, bus.count);
        end
        tick();
    endtask

    task automatic test_clr_midway();
        int t0;
        t0 = term_cnt;
        bus.start = 1'b1;
        bus.init_count = 32'd4;
        bus.init_esi = 32'h400;
        bus.init_edi = 32'h500;
        bus.size = 2'd2;
        bus.df = 1'b0;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.count !== 32'h0 || bus.esi !== 32'h0 ||
            bus.edi !== 32'h0 || bus.terminate !== 1'b0) begin
            failures++;
            $display("FAIL clr_wait: got busy=%b %h %h %h term=%b want 0 0 0 0 0",
                     bus.busy, bus.count, bus.esi, bus.edi, bus.terminate);
        end
        tick();
        checks++;
        if (term_cnt != t0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL clr_no_term: got term=%0d busy=%b want 0 0",
                     term_cnt - t0, bus.busy);
        end
    endtask

    initial begin
        CLR = 1'b1;
        bus.start = 1'b0;
        bus.init_count = '0;
        bus.init_esi = '0;
        bus.init_edi = '0;
        bus.size = 2'd0;
        bus.df = 1'b0;
        bus.cmp_done = 1'b0;
        bus.zf = 1'b0;
        bus.stall_in = 1'b0;
        test_reset();
        test_zero_count();
        test_rep("count3_byte", 32'd3, 32'h100, 32'h200, 2'd0, 1'b0, 0);
        test_rep("zf_early", 32'd5, 32'h1000, 32'h2000, 2'd1, 1'b0, 2);
        test_rep("wrap_down", 32'd2, 32'h2, 32'h8, 2'd2, 1'b1, 0);
        test_rep("rsvd_size", 32'd1, 32'hFFFFFFFE, 32'h0, 2'd3, 1'b0, 0);
        test_stall();
        test_clr_midway();
        test_rep("after_clr", 32'd2, 32'h30, 32'h40, 2'd1, 1'b1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
